// File: rtl/sprite_motion_controller.sv
// Sprite motion controller: once per frame, at the first pixel of vertical
// blanking, steps the sprite position by speed_in on each axis. An axis
// bounces off the screen edges. The position only changes inside blanking,
// so the renderer never sees x/y move during active video.
module sprite_motion_controller #(
  parameter int SCREEN_W = 1280,
  parameter int SCREEN_H = 720,
  parameter int SPRITE_W = 256,
  parameter int SPRITE_H = 256,
  parameter int INIT_X   = 0,
  parameter int INIT_Y   = 0
) (
  input  logic        pixel_clk_in,
  input  logic        rst_in,
  input  logic [10:0] hcount_in,
  input  logic [9:0]  vcount_in,
  input  logic        enable_in,
  input  logic [3:0]  speed_in,
  output logic [10:0] x_out,
  output logic [9:0]  y_out,
  output logic        dir_x_out,
  output logic        dir_y_out,
  output logic        frame_tick_out
);

  // Comparisons run one bit wider than the position so x+spd cannot wrap.
  localparam logic [11:0] XMAX = 12'(SCREEN_W - SPRITE_W);
  localparam logic [10:0] YMAX = 11'(SCREEN_H - SPRITE_H);

  localparam logic [2:0] S_WAIT   = 3'd0;
  localparam logic [2:0] S_LATCH  = 3'd1;
  localparam logic [2:0] S_STEP_X = 3'd2;
  localparam logic [2:0] S_STEP_Y = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  logic [2:0]  state_q, state_d;
  logic        trig_q, trig_prev_q;
  logic [3:0]  spd_q, spd_d;
  logic [10:0] x_q, x_d;
  logic [9:0]  y_q, y_d;
  logic        dir_x_q, dir_x_d;
  logic        dir_y_q, dir_y_d;
  logic        tick_q, tick_d;

  logic        trig_now;
  logic        trig_rise;
  logic [11:0] x_sum;
  logic [10:0] y_sum;

  assign trig_now  = (hcount_in == 11'd0) && (vcount_in == 10'(SCREEN_H));
  // Only the first cycle of a held trigger starts an update.
  assign trig_rise = trig_q && !trig_prev_q;
  assign x_sum     = {1'b0, x_q} + {8'd0, spd_q};
  assign y_sum     = {1'b0, y_q} + {7'd0, spd_q};

  // Next-state logic: one cycle per FSM state, one axis updated per step.
  always_comb begin
    // NOTE: every _d gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_d = state_q;
    spd_d   = spd_q;
    x_d     = x_q;
    y_d     = y_q;
    dir_x_d = dir_x_q;
    dir_y_d = dir_y_q;
    tick_d  = 1'b0;
    case (state_q)
      S_WAIT: begin
        if (trig_rise && enable_in) state_d = S_LATCH;
      end
      S_LATCH: begin
        spd_d   = speed_in;
        state_d = S_STEP_X;
      end
      S_STEP_X: begin
        if (spd_q != 4'd0) begin
          if (dir_x_q) begin
            if (x_sum >= XMAX) begin
              x_d     = XMAX[10:0];
              dir_x_d = 1'b0;
            end else begin
              x_d = x_sum[10:0];
            end
          end else if ({1'b0, x_q} <= {8'd0, spd_q}) begin
            x_d     = 11'd0;
            dir_x_d = 1'b1;
          end else begin
            x_d = x_q - {7'd0, spd_q};
          end
        end
        state_d = S_STEP_Y;
      end
      S_STEP_Y: begin
        if (spd_q != 4'd0) begin
          if (dir_y_q) begin
            if (y_sum >= YMAX) begin
              y_d     = YMAX[9:0];
              dir_y_d = 1'b0;
            end else begin
              y_d = y_sum[9:0];
            end
          end else if ({1'b0, y_q} <= {7'd0, spd_q}) begin
            y_d     = 10'd0;
            dir_y_d = 1'b1;
          end else begin
            y_d = y_q - {6'd0, spd_q};
          end
        end
        state_d = S_DONE;
      end
      S_DONE: begin
        tick_d  = 1'b1;
        state_d = S_WAIT;
      end
      default: state_d = S_WAIT;
    endcase
  end

  // State registers; a reset at any point abandons an update in flight.
  always_ff @(posedge pixel_clk_in) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (rst_in) begin
      state_q     <= S_WAIT;
      trig_q      <= 1'b0;
      trig_prev_q <= 1'b0;
      spd_q       <= 4'd0;
      x_q         <= 11'(INIT_X);
      y_q         <= 10'(INIT_Y);
      dir_x_q     <= 1'b1;
      dir_y_q     <= 1'b1;
      tick_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      trig_q      <= trig_now;
      trig_prev_q <= trig_q;
      spd_q       <= spd_d;
      x_q         <= x_d;
      y_q         <= y_d;
      dir_x_q     <= dir_x_d;
      dir_y_q     <= dir_y_d;
      tick_q      <= tick_d;
    end
  end

  assign x_out          = x_q;
  assign y_out          = y_q;
  assign dir_x_out      = dir_x_q;
  assign dir_y_out      = dir_y_q;
  assign frame_tick_out = tick_q;

endmodule
